// File: rtl/adc_spi_controller.sv
// ADC128S022 serial master: one 16-SCLK frame per accepted start, result
// presented with a one-cycle data_valid pulse.
//   state | meaning
//   IDLE  | CS high, SCLK high, waiting for start
//   SETUP | CS low, SCLK high for one half-period (CS setup)
//   SHIFT | 16 SCLK bits: address out on adc_din, result in from adc_dout
//   DONE  | CS high quiet half-period; result published on entry
module adc_spi_controller #(
    parameter int SCLK_HALF = 8,
    parameter int DATA_W    = 12,
    parameter int CH_W      = 3
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   channel,
    output logic              busy,
    output logic              data_valid,
    output logic [DATA_W-1:0] adc_data,
    output logic [CH_W-1:0]   ch_out,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic              adc_din,
    input  logic              adc_dout
);

    localparam int CNT_W = (SCLK_HALF > 2) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [3:0] BIT_LAST = 4'd15;
    localparam logic [3:0] BIT_FIRST_DATA = 4'(16 - DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]   prev_ch_q, prev_ch_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_out_q, ch_out_d;
    logic              valid_q, valid_d;
    logic              cs_n_q, cs_n_d;
    logic              sck_q, sck_d;
    logic              din_q, din_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic [CNT_W-1:0]  cnt_wrap;
    logic [3:0]        bit_nxt;
    logic              din_nxt;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            cur_ch_q  <= '0;
            prev_ch_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ch_out_q  <= '0;
            valid_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b1;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            cur_ch_q  <= cur_ch_d;
            prev_ch_q <= prev_ch_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ch_out_q  <= ch_out_d;
            valid_q   <= valid_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        cur_ch_d  = cur_ch_q;
        prev_ch_d = prev_ch_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ch_out_d  = ch_out_q;
        valid_d   = 1'b0;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        din_d     = din_q;
        busy_d    = busy_q;

        tick     = (cnt_q == CNT_LAST);
        cnt_wrap = tick ? '0 : cnt_q + CNT_W'(1);
        bit_nxt  = bit_q + 4'd1;

        // Address bits go out MSB first on bits 2..CH_W+1 of the frame.
        din_nxt = 1'b0;
        for (int i = 0; i < CH_W; i++) begin
            if (bit_nxt == 4'(2 + i)) din_nxt = cur_ch_q[CH_W-1-i];
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    cur_ch_d = channel;
                    state_d  = SETUP;
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    sck_d    = 1'b1;
                end
            end
            SETUP: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    sck_d   = 1'b0;
                    din_d   = 1'b0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sck_d   = 1'b1;
                        if (bit_q >= BIT_FIRST_DATA)
                            shift_d = {shift_q[DATA_W-2:0], adc_dout};
                    end else if (bit_q != BIT_LAST) begin
                        bit_d   = bit_nxt;
                        phase_d = 1'b0;
                        sck_d   = 1'b0;
                        din_d   = din_nxt;
                    end else begin
                        // The ADC returns the channel addressed in the previous frame.
                        state_d   = DONE;
                        cs_n_d    = 1'b1;
                        sck_d     = 1'b1;
                        din_d     = 1'b0;
                        data_d    = shift_q;
                        ch_out_d  = prev_ch_q;
                        prev_ch_d = cur_ch_q;
                        valid_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign adc_data   = data_q;
    assign ch_out     = ch_out_q;
    assign adc_cs_n   = cs_n_q;
    assign adc_sck    = sck_q;
    assign adc_din    = din_q;

endmodule

// File: tb/tb_adc_spi_controller.sv
// Directed bench for adc_spi_controller: ADC serial model, scoreboard of
// expected {data, channel} per frame, timing measurements on CS/busy/SCLK.
module tb_adc_spi_controller;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic [2:0]  channel = 3'd0;
    logic        busy, data_valid, adc_cs_n, adc_sck, adc_din;
    logic [11:0] adc_data;
    logic [2:0]  ch_out;
    logic        adc_dout = 1'b0;

    logic        rst2     = 1'b1;
    logic        start2   = 1'b0;
    logic [2:0]  channel2 = 3'd3;
    logic        busy2, data_valid2, adc_cs_n2, adc_sck2, adc_din2;
    logic [11:0] adc_data2;
    logic [2:0]  ch_out2;
    logic        adc_dout2 = 1'b1;

    always #10 clk_50M = ~clk_50M;

    adc_spi_controller dut (
        .clk_50M(clk_50M), .rst(rst), .start(start), .channel(channel),
        .busy(busy), .data_valid(data_valid), .adc_data(adc_data), .ch_out(ch_out),
        .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_din(adc_din), .adc_dout(adc_dout)
    );

    adc_spi_controller #(.SCLK_HALF(2)) dut2 (
        .clk_50M(clk_50M), .rst(rst2), .start(start2), .channel(channel2),
        .busy(busy2), .data_valid(data_valid2), .adc_data(adc_data2), .ch_out(ch_out2),
        .adc_cs_n(adc_cs_n2), .adc_sck(adc_sck2), .adc_din(adc_din2), .adc_dout(adc_dout2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ADC model: DOUT changes on SCLK falling edges, address sampled on rising.
    logic [11:0] adc_val  = 12'h000;
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] din_bits = 16'h0000;
    int          sck_fall = 0;
    int          sck_rise = 0;

    always @(negedge adc_cs_n) begin
        adc_word = {4'h0, adc_val};
        sck_fall = 0;
        sck_rise = 0;
        din_bits = '0;
        adc_dout = adc_word[15];
    end

    always @(negedge adc_sck) begin
        if (!adc_cs_n) begin
            if (sck_fall < 16) adc_dout = adc_word[15 - sck_fall];
            sck_fall++;
        end
    end

    always @(posedge adc_sck) begin
        if (!adc_cs_n) begin
            din_bits = {din_bits[14:0], adc_din};
            sck_rise++;
        end
    end

    typedef struct packed {
        logic [11:0] d;
        logic [2:0]  ch;
    } exp_t;

    exp_t sb[$];
    logic [2:0] model_prev = 3'd0;

    int   cyc = 0, cs_low = 0, last_cs_low = 0, busy_hi = 0, last_busy = 0;
    int   cs_fall_cyc = 0, valid_dly = 0, n_valid = 0;
    logic cs_prev = 1'b1;

    always @(negedge clk_50M) begin
        exp_t e;
        cyc++;
        if (!adc_cs_n) begin
            if (cs_prev) cs_fall_cyc = cyc;
            cs_low++;
        end else if (cs_low != 0) begin
            last_cs_low = cs_low;
            cs_low = 0;
        end
        cs_prev = adc_cs_n;
        if (busy) busy_hi++;
        else if (busy_hi != 0) begin
            last_busy = busy_hi;
            busy_hi = 0;
        end
        if (data_valid) begin
            n_valid++;
            valid_dly = cyc - cs_fall_cyc;
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("adc_data", adc_data, e.d);
                check("ch_out", ch_out, e.ch);
            end
        end
    end

    int   cyc2 = 0, fall2 = 0, period2 = 0, sck2_last = 0, sck2_period = 0, n_valid2 = 0;
    logic cs2_prev = 1'b1, sck2_prev = 1'b1;

    always @(negedge clk_50M) begin
        cyc2++;
        if (cs2_prev && !adc_cs_n2) begin
            if (fall2 != 0) period2 = cyc2 - fall2;
            fall2 = cyc2;
            sck2_last = 0;
        end
        if (!sck2_prev && adc_sck2 && !adc_cs_n2) begin
            if (sck2_last != 0) sck2_period = cyc2 - sck2_last;
            sck2_last = cyc2;
        end
        cs2_prev  = adc_cs_n2;
        sck2_prev = adc_sck2;
        if (data_valid2) n_valid2++;
    end

    task automatic pulse_start();
        @(negedge clk_50M);
        start = 1'b1;
        @(negedge clk_50M);
        start = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk_50M);
            t++;
        end
        check(tag, busy, 0);
        @(negedge clk_50M);
    endtask

    task automatic frame(logic [2:0] ch, logic [11:0] val);
        exp_t e;
        adc_val = val;
        channel = ch;
        e.d  = val;
        e.ch = model_prev;
        sb.push_back(e);
        model_prev = ch;
        pulse_start();
        wait_idle("frame_end");
    endtask

    initial begin
        int   v0;
        int   t;
        exp_t e;

        repeat (5) @(negedge clk_50M);
        rst = 1'b0;
        repeat (500) @(negedge clk_50M);
        check("idle_cs_n", adc_cs_n, 1);
        check("idle_sck", adc_sck, 1);
        check("idle_busy", busy, 0);
        check("idle_din", adc_din, 0);
        check("idle_adc_data", adc_data, 0);
        check("idle_ch_out", ch_out, 0);
        check("idle_no_valid", n_valid, 0);

        frame(3'd5, 12'hA5C);
        check("f1_din_bits", din_bits, 16'h2800);
        check("f1_sck_rise", sck_rise, 16);
        check("f1_sck_fall", sck_fall, 16);
        check("f1_cs_low", last_cs_low, 264);
        check("f1_busy_len", last_busy, 272);
        check("f1_valid_dly", valid_dly, 264);
        check("f1_n_valid", n_valid, 1);
        repeat (20) @(negedge clk_50M);
        check("f1_data_held", adc_data, 12'hA5C);

        frame(3'd2, 12'h001);
        check("f2_din_bits", din_bits, 16'h1000);
        frame(3'd7, 12'h3C3);
        check("f3_din_bits", din_bits, 16'h3800);
        check("f3_n_valid", n_valid, 3);

        // start and channel change during an active frame must be ignored
        v0 = n_valid;
        adc_val = 12'h7E1;
        channel = 3'd1;
        e.d  = 12'h7E1;
        e.ch = model_prev;
        sb.push_back(e);
        model_prev = 3'd1;
        pulse_start();
        repeat (98) @(negedge clk_50M);
        start   = 1'b1;
        channel = 3'd6;
        @(negedge clk_50M);
        start = 1'b0;
        wait_idle("t4_end");
        check("t4_busy_len", last_busy, 272);
        check("t4_din_bits", din_bits, 16'h0800);
        repeat (300) @(negedge clk_50M);
        check("t4_one_valid", n_valid, v0 + 1);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_cs_n", adc_cs_n, 1);
        frame(3'd4, 12'h800);

        // reset in the middle of a frame
        v0 = n_valid;
        adc_val = 12'h555;
        channel = 3'd3;
        pulse_start();
        t = 0;
        while (sck_rise < 9 && t < 1000) begin
            @(negedge clk_50M);
            t++;
        end
        check("t5_reach_bit9", sck_rise >= 9, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_cs_n", adc_cs_n, 1);
        check("t5_rst_sck", adc_sck, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", data_valid, 0);
        @(negedge clk_50M);
        rst = 1'b0;
        repeat (300) @(negedge clk_50M);
        check("t5_no_valid", n_valid, v0);
        check("t5_data_cleared", adc_data, 0);
        model_prev = 3'd0;
        frame(3'd6, 12'h123);
        check("t5_next_frame", n_valid, v0 + 1);

        // back-to-back frames with SCLK_HALF=2 and start held high
        @(negedge clk_50M);
        rst2   = 1'b0;
        start2 = 1'b1;
        t = 0;
        while (n_valid2 < 4 && t < 2000) begin
            @(negedge clk_50M);
            t++;
        end
        check("t6_valids", n_valid2 >= 4, 1);
        check("t6_period", period2, 69);
        check("t6_sck_period", sck2_period, 4);
        check("t6_data", adc_data2, 12'hFFF);
        check("t6_ch_out", ch_out2, 3);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_spi_controller.md
Name: adc_spi_controller

Overview:
- Serial master for the DE0-Nano on-board ADC128S022 (8-channel, 12-bit, SPI-style).
- Runs on clk_50M and generates the ADC serial clock internally: 50 MHz / (2*SCLK_HALF) = 3.125 MHz by default.
- On a start request, runs one 16-SCLK frame: shifts the channel address out on adc_din and shifts the 12-bit result in from adc_dout.
- Presents the result with a one-cycle valid pulse to the algorithm / RISC-V side.

Parameters:
- SCLK_HALF, 8, clk_50M cycles per SCLK half-period (minimum 2).
- DATA_W, 12, conversion result width.
- CH_W, 3, channel address width.

Ports:
- clk_50M  in  1  50 MHz system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- channel  in  CH_W  channel address; latched when start is accepted.
- busy  out  1  high from the cycle after acceptance until the frame ends.
- data_valid  out  1  one-cycle pulse when adc_data/ch_out update.
- adc_data  out  DATA_W  last conversion result, held until the next update.
- ch_out  out  CH_W  channel that adc_data belongs to.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sck  out  1  ADC serial clock; idles high.
- adc_din  out  1  address bits to the ADC.
- adc_dout  in  1  serial data from the ADC.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - Outputs: adc_cs_n=1, adc_sck=1, adc_din=0, busy=0, data_valid=0, adc_data=0, ch_out=0.
  - Internal: half-period counter=0, bit counter=0, prev_ch=0, state=IDLE.
  - An aborted frame never produces data_valid.
- Tick: internal counter 0..SCLK_HALF-1. tick=1 when counter==SCLK_HALF-1; counter then wraps to 0. Counter is held at 0 in IDLE.
- IDLE:
  - start=1 → latch channel into cur_ch; next cycle state=SETUP, adc_cs_n=0, busy=1, adc_sck=1.
  - start=0 → stay.
- SETUP: lasts SCLK_HALF cycles with SCLK high (CS setup time). On tick → SHIFT, bit k=0, low phase.
- SHIFT: 16 bits k=0..15, each a low phase then a high phase, each phase SCLK_HALF cycles.
  - Entering the low phase of bit k: adc_sck=0; adc_din = cur_ch[2] for k=2, cur_ch[1] for k=3, cur_ch[0] for k=4, else 0.
  - Low→high transition (same clk_50M edge that sets adc_sck=1): if k>=4, shift adc_dout into the result register, MSB first (D11 at k=4, D0 at k=15). Bits k=0..3 are ignored (leading zeros).
  - End of the high phase: if k<15 → k+1, low phase. If k==15 → DONE.
- DONE:
  - Entry cycle: adc_cs_n=1, adc_sck=1, adc_din=0.
  - Same edge: adc_data=shift register, ch_out=prev_ch, prev_ch=cur_ch, and data_valid=1 for exactly that one cycle.
  - Stay SCLK_HALF cycles (CS high quiet time), then IDLE with busy=0.
- Pipelining: the ADC converts the channel addressed in the previous frame. ch_out therefore reports the previous frame's channel. The first frame after reset reports ch_out=0, which matches the ADC default of IN0.
- Timing (default SCLK_HALF=8):
  - adc_cs_n low for 33*SCLK_HALF = 264 cycles.
  - busy high for 34*SCLK_HALF = 272 cycles.
  - data_valid occurs 33*SCLK_HALF cycles after adc_cs_n falls.
  - Minimum start-to-start period: 273 cycles.
- start while busy: ignored, not queued.
- start held high continuously: a new frame is accepted on the first IDLE cycle after DONE.
- channel changes while busy: no effect on the current frame.
- adc_sck toggles only while adc_cs_n=0. Exactly 16 falling and 16 rising edges per frame.

Test Plan:
- Reset then idle 500 cycles → adc_cs_n=1, adc_sck=1, busy=0, data_valid never pulses, adc_data=0.
- start=1 for one cycle with channel=5, ADC model returns 0xA5C → adc_din carries 1,0,1 at bits 2..4; 16 SCLK rising edges; data_valid one cycle after 264 CS-low cycles; adc_data=0xA5C, ch_out=0.
- Second frame channel=2, model returns 0x001, then a third frame → second data_valid gives adc_data=0x001, ch_out=5; third gives ch_out=2.
- start pulsed at cycle 100 of an active frame → ignored; exactly one data_valid; busy drops at 272.
- rst asserted at SCLK bit 9 → immediately adc_cs_n=1, adc_sck=1, busy=0; no data_valid; next frame completes normally with ch_out=0.
- SCLK_HALF=2, start held high → back-to-back frames every 69 cycles; measured SCLK period = 4 cycles.
